// File: rtl/stats_collect.sv
// Per-channel event accumulators flushed as sparse AXI-stream increment beats
// (tdata = amount, tid = counter index) on a periodic timer or an update request.
module stats_collect #(
    parameter int unsigned COUNT          = 8,
    parameter int unsigned INC_WIDTH      = 8,
    parameter int unsigned STAT_INC_WIDTH = 16,
    parameter int unsigned STAT_ID_WIDTH  = 8,
    parameter int unsigned ID_BASE        = 0,
    parameter int unsigned UPDATE_PERIOD  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COUNT*INC_WIDTH-1:0]   stat_inc_i,
    input  logic [COUNT-1:0]             stat_valid_i,
    input  logic                         update_i,
    output logic [STAT_INC_WIDTH-1:0]    m_axis_stat_tdata_o,
    output logic [STAT_ID_WIDTH-1:0]     m_axis_stat_tid_o,
    output logic                         m_axis_stat_tvalid_o,
    input  logic                         m_axis_stat_tready_i
);

    localparam int unsigned ChW    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int unsigned TimerW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e                        state_q, state_d;
    logic [ChW-1:0]                ch_q, ch_d;
    logic                          pending_q, pending_d;
    logic                          tvalid_q, tvalid_d;
    logic [STAT_INC_WIDTH-1:0]     tdata_q, tdata_d;
    logic [STAT_ID_WIDTH-1:0]      tid_q, tid_d;

    logic                          timer_hit;
    logic                          trigger;
    logic [COUNT*STAT_INC_WIDTH-1:0] acc_flat;
    logic [STAT_INC_WIDTH-1:0]     acc_sel;
    logic                          out_free;
    logic                          capture;
    logic                          advance;
    logic                          last_ch;

    if (UPDATE_PERIOD == 0) begin : g_no_timer
        assign timer_hit = 1'b0;
    end else begin : g_timer
        localparam logic [TimerW-1:0] Reload = TimerW'(UPDATE_PERIOD - 1);
        logic [TimerW-1:0] timer_q, timer_d;

        assign timer_hit = (timer_q == '0);
        assign timer_d   = timer_hit ? Reload : timer_q - TimerW'(1);

        always_ff @(posedge clk) begin
            if (rst) begin
                timer_q <= Reload;
            end else begin
                timer_q <= timer_d;
            end
        end
    end

    assign trigger  = update_i || timer_hit;
    assign acc_sel  = acc_flat[int'(ch_q)*STAT_INC_WIDTH +: STAT_INC_WIDTH];
    assign out_free = !tvalid_q || m_axis_stat_tready_i;
    assign capture  = (state_q == StScan) && (acc_sel != '0) && out_free;
    // A zero channel is skipped even while the output register is busy.
    assign advance  = (state_q == StScan) && ((acc_sel == '0) || out_free);
    assign last_ch  = (ch_q == ChW'(COUNT - 1));

    for (genvar i = 0; i < COUNT; i++) begin : g_acc
        logic [STAT_INC_WIDTH-1:0] acc_q, acc_d;
        logic [STAT_INC_WIDTH-1:0] inc_ext;
        logic [STAT_INC_WIDTH:0]   sum;
        logic [STAT_INC_WIDTH-1:0] sat;
        logic                      hit;

        assign inc_ext = STAT_INC_WIDTH'(stat_inc_i[i*INC_WIDTH +: INC_WIDTH]);
        assign sum     = {1'b0, acc_q} + {1'b0, inc_ext};
        assign sat     = sum[STAT_INC_WIDTH] ? '1 : sum[STAT_INC_WIDTH-1:0];
        assign hit     = capture && (ch_q == ChW'(i));

        // On capture the old value leaves as a beat; a coincident increment seeds the new one.
        always_comb begin
            acc_d = acc_q;
            if (stat_valid_i[i]) begin
                acc_d = sat;
            end
            if (hit) begin
                acc_d = stat_valid_i[i] ? inc_ext : '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end

        assign acc_flat[i*STAT_INC_WIDTH +: STAT_INC_WIDTH] = acc_q;
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        pending_d = pending_q || trigger;
        tvalid_d  = tvalid_q && !m_axis_stat_tready_i;
        tdata_d   = tdata_q;
        tid_d     = tid_q;

        case (state_q)
            StIdle: begin
                if (pending_q) begin
                    pending_d = trigger;
                    state_d   = StScan;
                    ch_d      = '0;
                end
            end
            StScan: begin
                if (advance) begin
                    if (last_ch) begin
                        state_d = StIdle;
                        ch_d    = '0;
                    end else begin
                        ch_d = ch_q + ChW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            tvalid_d = 1'b1;
            tdata_d  = acc_sel;
            tid_d    = STAT_ID_WIDTH'(ID_BASE) + STAT_ID_WIDTH'(ch_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            pending_q <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tid_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            pending_q <= pending_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tid_q     <= tid_d;
        end
    end

    assign m_axis_stat_tdata_o  = tdata_q;
    assign m_axis_stat_tid_o    = tid_q;
    assign m_axis_stat_tvalid_o = tvalid_q;

endmodule

// File: doc/stats_collect.md
# stats_collect

Statistics collector that produces the increment stream consumed by the statistics counter block. It accumulates COUNT parallel event/increment inputs into per-channel local accumulators. On a periodic timer or an explicit update request, it scans all channels and emits each non-zero accumulator as one AXI-stream increment beat (tdata = amount, tid = counter index). It sits next to the datapath blocks that generate events, so that narrow per-cycle increments become sparse, wide increments to the central counter RAM.

## Interface
- COUNT, 8: number of input channels (≥1)
- INC_WIDTH, 8: width of each per-channel increment input
- STAT_INC_WIDTH, 16: accumulator and output increment width (≥ INC_WIDTH)
- STAT_ID_WIDTH, 8: output tid width (≥ $clog2(COUNT))
- ID_BASE, 0: tid of channel 0; channel i reports tid = ID_BASE + i (mod 2^STAT_ID_WIDTH)
- UPDATE_PERIOD, 1024: timer period in clk cycles; 0 disables the timer
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stat_inc  in  COUNT*INC_WIDTH  per-channel increment, channel i at bits [i*INC_WIDTH +: INC_WIDTH]
- stat_valid  in  COUNT  per-channel qualifier; increment applied only when set
- update  in  1  single-cycle flush request
- m_axis_stat_tdata  out  STAT_INC_WIDTH  increment amount
- m_axis_stat_tid  out  STAT_ID_WIDTH  counter index
- m_axis_stat_tvalid  out  1  beat valid
- m_axis_stat_tready  in  1  beat accepted

## Operation
- acc[i], STAT_INC_WIDTH bits, one per channel.
- Every cycle, for each i with stat_valid[i], acc[i] <= sat(acc[i] + zero-extended stat_inc[i]). sat clamps at all-ones. Overflow beyond the clamp is discarded.
- Flush trigger: the timer counts down from UPDATE_PERIOD-1 to 0, then reloads, free-running. Reaching 0 or update=1 sets flush_pending.
- FSM states:
  - IDLE: if flush_pending, clear it, set ch=0, go to SCAN.
  - SCAN: examine acc[ch], one channel per cycle.
    - acc[ch]==0: skip.
    - acc[ch]!=0 and output register free (!tvalid || tready): capture tdata=acc[ch], tid=ID_BASE+ch, tvalid=1. In the same cycle acc[ch] <= (stat_valid[ch] ? stat_inc[ch] : 0), so no concurrent increment is lost.
    - acc[ch]!=0 and output register busy: stall on ch, with no capture and no advance.
    - After skipping or capturing, ch increments. When ch==COUNT-1 is done, go to IDLE.
- A trigger arriving during SCAN sets flush_pending. The next scan starts on the first IDLE cycle after the current scan completes. Multiple triggers merge into one pending flush.
- Accumulation continues in all states, including during stalls.
- Output register: tvalid stays high until tready. tdata and tid are stable while tvalid && !tready. Zero-amount beats are never emitted.

## Timing
- Reset values:
  - m_axis_stat_tvalid=0, tdata=0, tid=0
  - all acc=0, flush_pending=0, state IDLE, ch=0
  - timer reloaded to UPDATE_PERIOD-1
- Reset mid-scan or mid-beat drops the pending beat and all accumulated counts.
- Latency:
  - update at cycle N: pending at N+1, SCAN at N+2, first capture at N+2, tvalid at N+3.
  - With tready held high, a full scan takes exactly COUNT cycles in SCAN; back-to-back beats are possible every cycle.
- Increment latency: stat_valid at cycle N is reflected in acc[i] at N+1. It is included in a capture at cycle ≥ N+1.
- The timer keeps counting during SCAN.
- The output is a standard AXI-stream register handshake: a transfer occurs on the cycle tvalid && tready are both high.

## Test plan
- Reset: hold rst 5 cycles with stat_valid toggling -> tvalid=0 throughout and one cycle after; no beats until a trigger.
- Basic flush: COUNT=4, ID_BASE=0x10, tready=1. Apply ch1 +5 three times and ch3 +7 once, then pulse update -> exactly two beats, (tid 0x11, tdata 15) then (tid 0x13, tdata 7). The next update produces no beats.
- Coincident increment: acc[0]=10; stat_valid[0]=1 with stat_inc=2 on ch0's capture cycle -> beat tdata=10. A later update emits tdata=2.
- Backpressure: 3 non-zero channels, tready=0 for 20 cycles after the first tvalid -> tvalid high and tdata/tid constant. Meanwhile increments to the unsent channels still accumulate. On release, the remaining beats carry the full accumulated values in channel order.
- Saturation: STAT_INC_WIDTH=16, INC_WIDTH=8, ch2 +0xFF for 300 consecutive cycles, then update -> single beat tid=2, tdata=0xFFFF.
- Timer and merge: UPDATE_PERIOD=64, no update, single ch0 +1 -> beat tdata=1 within 64+COUNT+2 cycles. Pulsing update twice during a scan -> exactly one extra scan follows.
